cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) among the execute-stage functional units (add/sub, multiply, load, etc.). Each cycle it selects at most one unit holding a completed `CDB_packet_t`. It acknowledges that unit with `yumi` and registers the packet onto the CDB for broadcast to the ROB and reservation stations. It sits between the functional units' `valid_out`/`yumi_in` handshake and the CDB consumers.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting functional units (≥2).
- `IDX_W`, default `$clog2(N_REQ)`: width of the priority pointer.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  bit i is unit i's `valid_out`; held high until acknowledged.
- `req_pkt`  in  N_REQ × CDB_packet_t  unit i's result packet; stable while `req_valid[i]`.
- `yumi`  out  N_REQ  one-hot-or-zero grant, wired to unit i's `yumi_in`.
- `cdb_stall`  in  1  consumers cannot accept a new broadcast this cycle.
- `flush`  in  1  branch mispredict; discard the pending broadcast.
- `cdb_valid`  out  1  `cdb_pkt` is valid this cycle.
- `cdb_pkt`  out  CDB_packet_t  registered broadcast packet.

## Operation
- State: `ptr` (IDX_W bits, highest-priority requester), `cdb_valid`, `cdb_pkt`.
- Grant enable: `can_issue = ~flush & ~(cdb_stall & cdb_valid)`.
  - A stalled broadcast is held.
  - A stall with an empty output does not block a grant.
- Selection: search `req_valid` from index `ptr` upward, wrapping modulo N_REQ. The first set bit is the winner `w`.
- `yumi[w]=1` only when `can_issue`; all other `yumi` bits are 0. `yumi` is combinational from `req_valid`, `ptr`, `flush`, `cdb_stall`, `cdb_valid`.
- On a grant:
  - `cdb_pkt <= req_pkt[w]`, `cdb_valid <= 1`.
  - `ptr <= (w+1) mod N_REQ`. For non-power-of-2 N_REQ, wrap explicitly; never produce an index ≥ N_REQ.
- No grant, not stalled, no flush: `cdb_valid <= 0`, `ptr` unchanged.
- Stall with `cdb_valid=1` (no flush): hold `cdb_pkt`, `cdb_valid`, `ptr`.
- Flush (overrides stall):
  - `yumi` all 0.
  - `cdb_valid <= 0`; `cdb_pkt` contents don't-care.
  - `ptr` unchanged.
- Packet fields (`dest_ROB_entry`, `result`, `branch_result`, `from_memory`) pass through unmodified.
- Reset (overrides flush and stall): `ptr=0`, `cdb_valid=0`, `cdb_pkt=0`. `yumi` is forced all-0 during any cycle with `reset=1`. Reset mid-stall drops the held packet.

## Timing
- Reset values: `cdb_valid=0`, `cdb_pkt='0`, `yumi='0`, `ptr=0`.
- Latency: a packet granted in cycle t (yumi high in t) is on the CDB in cycle t+1.
- Throughput: 1 broadcast/cycle while any request is pending and there is no stall or flush.
- Handshake:
  - A unit drops `req_valid` at the edge ending its yumi cycle.
  - The arbiter never issues two yumis to the same unit for one result; the FU contract guarantees `req_valid` is low the cycle after yumi.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once per N_REQ grant cycles. Worst-case wait is N_REQ−1 grant cycles.
- Simultaneous stall and new request with `cdb_valid=1`: no yumi; the request waits.
- Flush and request in the same cycle: no yumi. The unit's request persists; squashing it is the FU's and ROB's responsibility.

## Structure
- Shared package `structs.svh`:
  - `CDB_packet_t`: `dest_ROB_entry` [3:0], `result` [31:0], `branch_result`, `from_memory`.
  - `ROB_IDX_W=4`.
  - Requester index constants: `CDB_REQ_ADD=0`, `CDB_REQ_MUL=1`, `CDB_REQ_LD=2`, `CDB_REQ_BR=3`.
- Sub-module `rr_pick`: combinational rotate/find-first-set/unrotate.
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: `onehot[N_REQ]`, `idx[IDX_W]`, `any`.
- The top level holds the registers and the `can_issue`/flush/stall logic.

## Test plan
- Reset then idle: all `req_valid=0` for 5 cycles → `yumi=0`, `cdb_valid=0` every cycle, `ptr=0`.
- Single requester: `req_valid=4'b0100`, pkt {rob=5, result=0x0000_0007} at cycle 2 → `yumi=4'b0100` in cycle 2; cycle 3 `cdb_valid=1` with rob 5, result 7; `ptr=3`.
- Full contention: `req_valid=4'b1111` held (each unit reasserts after 1 idle cycle) for 12 grants from `ptr=0` → grant order 0,1,2,3,0,1,… with no unit granted twice in 4 consecutive grants.
- Stall: packet on CDB with `cdb_stall=1` for 3 cycles and `req_valid=4'b0010` → `cdb_pkt` and `cdb_valid` unchanged, `yumi=0` for 3 cycles; unit 1 granted the cycle stall drops, broadcast the next cycle.
- Flush: grant to unit 0 in cycle t, `flush=1` in t+1 with `req_valid=4'b1000` → `yumi=0` in t+1; `cdb_valid=0` in t+2; unit 3 granted in t+2 when flush is low.
- Wrap with N_REQ=3: `ptr=2`, `req_valid=3'b011` → grant unit 0, `ptr=1`; next grant unit 1, `ptr=2`; never `ptr=3`.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types for the execute-stage arbiter and the units that feed it.
// Holds the broadcast packet layout and the fixed requester slot numbers.
package cdb_arbiter_pkg;

  localparam int ROB_IDX_W = 4;

  localparam int CDB_REQ_ADD = 0;
  localparam int CDB_REQ_MUL = 1;
  localparam int CDB_REQ_LD  = 2;
  localparam int CDB_REQ_BR  = 3;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] dest_ROB_entry;
    logic [31:0]          result;
    logic                 branch_result;
    logic                 from_memory;
  } CDB_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N_REQ. This works for N_REQ values that are not a power of two.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] slot_s;
  logic             hit_s;

  // Walk the slots farthest-first so that the slot nearest ptr wins.
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    slot_s = '0;
    hit_s  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr} + (IDX_W+1)'(k);
      slot_s = (cand_s >= N_EXT) ? IDX_W'(cand_s - N_EXT) : cand_s[IDX_W-1:0];
      hit_s  = req[slot_s];
      idx    = hit_s ? slot_s : idx;
      any    = any | hit_s;
    end
    onehot = any ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter. It grants one finished functional unit per
// cycle and registers that unit's packet for broadcast. Stalls hold the bus. Flushes drop it.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  input  CDB_packet_t       req_pkt [N_REQ],
  output logic [N_REQ-1:0]  yumi,
  input  logic              cdb_stall,
  input  logic              flush,
  output logic              cdb_valid,
  output CDB_packet_t       cdb_pkt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic             cdb_valid_r, cdb_valid_nxt_s;
  CDB_packet_t      cdb_pkt_r, cdb_pkt_nxt_s;
  logic [N_REQ-1:0] onehot_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  logic             can_issue_s;
  logic             grant_s;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_r),
    .onehot (onehot_s),
    .idx    (idx_s),
    .any    (any_s)
  );

  // A stall only blocks a grant when a broadcast is actually occupying the bus.
  assign can_issue_s = ~flush & ~(cdb_stall & cdb_valid_r);
  assign grant_s     = can_issue_s & any_s & ~reset;
  assign yumi        = grant_s ? onehot_s : {N_REQ{1'b0}};

  // Next-state selection: flush, then held stall, then grant, then idle.
  always_comb begin
    ptr_nxt_s       = ptr_r;
    cdb_valid_nxt_s = cdb_valid_r;
    cdb_pkt_nxt_s   = cdb_pkt_r;
    if (flush) begin
      cdb_valid_nxt_s = 1'b0;
    end else if (cdb_stall && cdb_valid_r) begin
      cdb_valid_nxt_s = 1'b1;
    end else if (any_s) begin
      cdb_valid_nxt_s = 1'b1;
      cdb_pkt_nxt_s   = req_pkt[idx_s];
      ptr_nxt_s       = (idx_s == LAST_IDX) ? {IDX_W{1'b0}} : idx_s + IDX_W'(1);
    end else begin
      cdb_valid_nxt_s = 1'b0;
    end
  end

  // State registers; reset overrides flush and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r       <= {IDX_W{1'b0}};
      cdb_valid_r <= 1'b0;
      cdb_pkt_r   <= '0;
    end else begin
      ptr_r       <= ptr_nxt_s;
      cdb_valid_r <= cdb_valid_nxt_s;
      cdb_pkt_r   <= cdb_pkt_nxt_s;
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_pkt   = cdb_pkt_r;

endmodule
